ddr5_power_sequencer: RTL and testbench
=======================================

// Module: ddr5_power_sequencer
// PURPOSE
//  Sequences DDR5 board power-up/down for the tester: VIN_BULK, then VIN_MGMT, waits for PGOOD,
//  holds RESET_n low for tINIT1, releases it, enables CK after tINIT3, then flags ready to the PHY.
//  Sits between the SoC CSRs (start/shutdown/fault_clr) and the vin_*_en/ddr5_reset_n/pgood/alert_n pads.
//  Monitors PGOOD while powered; any loss forces a fault shutdown.
// PARAMETERS
//  CNT_W          24     width of the shared dwell/timeout counter
//  BULK_DLY       1000   cycles from vin_bulk_en=1 to vin_mgmt_en=1 (>=1)
//  PGOOD_TO       100000 max cycles in S_PGOOD waiting for synced pgood=1 (>=1)
//  RST_HOLD       20000  tINIT1: cycles ddr5_reset_n held low after pgood seen (>=1)
//  INIT_DLY       5000   tINIT3: cycles after reset_n release before ck_en=1 and ready=1 (>=1)
//  ALERT_FILT     4      consecutive low cycles of synced alert_n counted as one alert event (>=1)
// PORTS
//  sys_clk        in   1  system clock
//  sys_rst_n      in   1  async active-low reset
//  start          in   1  1-cycle pulse: begin power-up (CSR)
//  shutdown       in   1  1-cycle pulse: orderly power-down (CSR)
//  fault_clr      in   1  1-cycle pulse: leave S_FAULT to S_OFF
//  pgood          in   1  board power-good, asynchronous
//  alert_n        in   1  DDR5 ALERT_n, asynchronous, active low
//  vin_bulk_en    out  1  bulk supply enable
//  vin_mgmt_en    out  1  management supply enable
//  ddr5_reset_n   out  1  DRAM RESET_n
//  ck_en          out  1  enable to CK output driver
//  ready          out  1  sequence complete, PHY may start init
//  fault          out  1  1 while in S_FAULT
//  fault_code     out  2  0 none, 1 PGOOD timeout, 2 PGOOD lost, latched on S_FAULT entry
//  state          out  3  current FSM state encoding (debug CSR)
//  alert_cnt      out  8  ALERT events seen in S_READY (feature-dependent)
// BEHAVIOUR
//  - Reset: all outputs 0 (ddr5_reset_n=0), state=S_OFF, counter=0, fault_code=0.
//  - pgood, alert_n pass 2-FF synchronizers (reset value 0 / 1); FSM sees them 2 cycles late.
//  - States: S_OFF=0, S_BULK=1, S_PGOOD=2, S_RST=3, S_INIT=4, S_READY=5, S_FAULT=6.
//  - Entry to a timed state loads counter=param-1; counter decrements each cycle; exit when 0 => dwell exactly N cycles.
//  - S_OFF: all outputs 0; start -> S_BULK.
//  - S_BULK: vin_bulk_en=1; after BULK_DLY -> S_PGOOD.
//  - S_PGOOD: bulk+mgmt=1; synced pgood=1 -> S_RST; counter 0 with pgood=0 -> S_FAULT, code 1.
//  - S_RST: supplies on, reset_n=0; after RST_HOLD -> S_INIT.
//  - S_INIT: reset_n=1; after INIT_DLY -> S_READY.
//  - S_READY: reset_n=1, ck_en=1, ready=1; holds indefinitely.
//  - In S_RST/S_INIT/S_READY synced pgood=0 -> S_FAULT, code 2 (takes priority over counter expiry).
//  - S_FAULT: all outputs 0 (reset_n=0, supplies off same cycle); fault=1; only fault_clr -> S_OFF, clears code.
//  - shutdown in any state except S_OFF/S_FAULT -> S_OFF next cycle; outputs 0 registered together.
//  - Priority: fault condition > shutdown > start; start ignored outside S_OFF; start+shutdown in S_OFF: stay.
//  - Outputs are registered, decoded from next state: change 1 cycle after the causing edge.
// CONFIGURATION
//  - DDR5_PWRSEQ_ALERT_MON_EN defined: in S_READY, synced alert_n low for ALERT_FILT consecutive cycles
//    increments alert_cnt once (saturates at 255); must return high before next event; cleared on S_OFF entry.
//  - Not defined: alert_n unused (no synchronizer), alert_cnt tied 8'd0.
// TESTING
//  Params BULK_DLY=4, PGOOD_TO=10, RST_HOLD=8, INIT_DLY=6, ALERT_FILT=3 unless stated.
//  - Nominal: start at t0, pgood=1 held -> vin_bulk_en t0+1, vin_mgmt_en t0+5, reset_n low 8 cycles, then ready after 6 more.
//  - Timeout: start, pgood held 0 -> after 10 cycles in S_PGOOD fault=1, fault_code=1, all enables 0; fault_clr -> state=0.
//  - PGOOD loss: in S_READY drop pgood -> 3 cycles later fault=1, code=2, ddr5_reset_n=0, ck_en=0.
//  - Shutdown mid S_RST -> next cycle state=0, all outputs 0; later start repeats full sequence.
//  - Async reset asserted in S_READY -> outputs 0 immediately, state=0, without clock.
//  - ALERT (macro on): alert_n low 2 cycles -> cnt 0; low 3 cycles -> cnt 1; low 10 cycles -> cnt 1 only; macro off -> cnt 0.

Source files
------------

// File: rtl/ddr5_power_sequencer.sv
// ddr5_power_sequencer
//   Brings up DDR5 board power for the tester in this order:
//     1. VIN_BULK on.
//     2. VIN_MGMT on.
//     3. Wait for PGOOD.
//     4. Hold RESET_n low for tINIT1, then release it.
//     5. Enable CK after tINIT3 and report ready to the PHY.
//   While the rails are up, a loss of PGOOD forces a fault shutdown. The fault is
//   latched until software clears it.
//
// Optional feature (compile-time macro):
//   DDR5_PWRSEQ_ALERT_MON_EN - when defined, counts filtered ALERT_n events in S_READY.
//                              When undefined, alert_n is ignored and o_alert_cnt is 0.
//
// Ports:
//   i_sys_clk       system clock
//   i_sys_rst_n     asynchronous active-low reset
//   i_start         1-cycle pulse, begin power-up
//   i_shutdown      1-cycle pulse, orderly power-down
//   i_fault_clr     1-cycle pulse, leave S_FAULT to S_OFF
//   i_pgood         board power-good (asynchronous)
//   i_alert_n       DDR5 ALERT_n (asynchronous, active low)
//   o_vin_bulk_en   bulk supply enable
//   o_vin_mgmt_en   management supply enable
//   o_ddr5_reset_n  DRAM RESET_n
//   o_ck_en         CK driver enable
//   o_ready         sequence complete
//   o_fault         high while in S_FAULT
//   o_fault_code    0 none, 1 PGOOD timeout, 2 PGOOD lost
//   o_state         current FSM state encoding
//   o_alert_cnt     ALERT events seen in S_READY (saturating)
module ddr5_power_sequencer #(
  parameter int CNT_W      = 24,
  parameter int BULK_DLY   = 1000,
  parameter int PGOOD_TO   = 100000,
  parameter int RST_HOLD   = 20000,
  parameter int INIT_DLY   = 5000,
  parameter int ALERT_FILT = 4
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst_n,
  input  logic       i_start,
  input  logic       i_shutdown,
  input  logic       i_fault_clr,
  input  logic       i_pgood,
  input  logic       i_alert_n,
  output logic       o_vin_bulk_en,
  output logic       o_vin_mgmt_en,
  output logic       o_ddr5_reset_n,
  output logic       o_ck_en,
  output logic       o_ready,
  output logic       o_fault,
  output logic [1:0] o_fault_code,
  output logic [2:0] o_state,
  output logic [7:0] o_alert_cnt
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_BULK  = 3'd1,
    S_PGOOD = 3'd2,
    S_RST   = 3'd3,
    S_INIT  = 3'd4,
    S_READY = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       r_fault_code;
  logic [1:0]       w_fault_code_next;
  logic             w_cnt_zero;

  // Output registers.
  logic r_vin_bulk_en;
  logic r_vin_mgmt_en;
  logic r_ddr5_reset_n;
  logic r_ck_en;
  logic r_ready;
  logic r_fault;

  // PGOOD synchronizer. The reset value of 0 means "not good".
  logic r_pgood_s1;
  logic r_pgood_s2;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_pgood_s1 <= 1'b0;
      r_pgood_s2 <= 1'b0;
    end else begin
      r_pgood_s1 <= i_pgood;
      r_pgood_s2 <= r_pgood_s1;
    end
  end

  assign w_cnt_zero = (r_cnt == '0);

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state      <= S_OFF;
      r_cnt        <= '0;
      r_fault_code <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_fault_code <= w_fault_code_next;
    end
  end

  // Next-state logic.
  // On entry to a timed state, the counter is loaded with N-1. The state is left on
  // the cycle the counter reads 0, so each timed state dwells exactly N cycles.
  // Priority within a state: fault condition, then shutdown, then normal progression.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
    w_fault_code_next = r_fault_code;
    case (r_state)
      S_OFF: begin
        // start together with shutdown is treated as no request.
        if (i_start && !i_shutdown) begin
          w_state_next = S_BULK;
          w_cnt_next   = CNT_W'(BULK_DLY - 1);
        end
      end
      S_BULK: begin
        if (i_shutdown) begin
          w_state_next = S_OFF;
        end else if (w_cnt_zero) begin
          w_state_next = S_PGOOD;
          w_cnt_next   = CNT_W'(PGOOD_TO - 1);
        end
      end
      S_PGOOD: begin
        if (!r_pgood_s2 && w_cnt_zero) begin
          w_state_next      = S_FAULT;
          w_fault_code_next = 2'd1;
        end else if (i_shutdown) begin
          w_state_next = S_OFF;
        end else if (r_pgood_s2) begin
          w_state_next = S_RST;
          w_cnt_next   = CNT_W'(RST_HOLD - 1);
        end
      end
      S_RST, S_INIT, S_READY: begin
        if (!r_pgood_s2) begin
          w_state_next      = S_FAULT;
          w_fault_code_next = 2'd2;
        end else if (i_shutdown) begin
          w_state_next = S_OFF;
        end else if (r_state == S_RST && w_cnt_zero) begin
          w_state_next = S_INIT;
          w_cnt_next   = CNT_W'(INIT_DLY - 1);
        end else if (r_state == S_INIT && w_cnt_zero) begin
          w_state_next = S_READY;
        end
      end
      S_FAULT: begin
        if (i_fault_clr) begin
          w_state_next      = S_OFF;
          w_fault_code_next = 2'd0;
        end
      end
      default: begin
        w_state_next = S_OFF;
      end
    endcase
  end

  // Outputs are decoded from the next state, so they change on the same edge as the
  // state register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_vin_bulk_en  <= 1'b0;
      r_vin_mgmt_en  <= 1'b0;
      r_ddr5_reset_n <= 1'b0;
      r_ck_en        <= 1'b0;
      r_ready        <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_vin_bulk_en  <= (w_state_next inside {S_BULK, S_PGOOD, S_RST, S_INIT, S_READY});
      r_vin_mgmt_en  <= (w_state_next inside {S_PGOOD, S_RST, S_INIT, S_READY});
      r_ddr5_reset_n <= (w_state_next inside {S_INIT, S_READY});
      r_ck_en        <= (w_state_next == S_READY);
      r_ready        <= (w_state_next == S_READY);
      r_fault        <= (w_state_next == S_FAULT);
    end
  end

  assign o_vin_bulk_en  = r_vin_bulk_en;
  assign o_vin_mgmt_en  = r_vin_mgmt_en;
  assign o_ddr5_reset_n = r_ddr5_reset_n;
  assign o_ck_en        = r_ck_en;
  assign o_ready        = r_ready;
  assign o_fault        = r_fault;
  assign o_fault_code   = r_fault_code;
  assign o_state        = r_state;

`ifdef DDR5_PWRSEQ_ALERT_MON_EN
  localparam int AF_W = (ALERT_FILT < 1) ? 1 : $clog2(ALERT_FILT + 1);

  logic            r_alert_s1;
  logic            r_alert_s2;
  logic [AF_W-1:0] r_alert_run;
  logic [7:0]      r_alert_cnt;

  // The run length saturates at ALERT_FILT. The count increments only on the cycle
  // the run reaches ALERT_FILT, so one long low pulse counts once. The line must go
  // high (which clears the run) before another event can be counted.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_alert_s1  <= 1'b1;
      r_alert_s2  <= 1'b1;
      r_alert_run <= '0;
      r_alert_cnt <= 8'd0;
    end else begin
      r_alert_s1 <= i_alert_n;
      r_alert_s2 <= r_alert_s1;
      if (w_state_next == S_OFF && r_state != S_OFF) begin
        r_alert_run <= '0;
        r_alert_cnt <= 8'd0;
      end else if (r_state == S_READY && !r_alert_s2) begin
        if (r_alert_run != AF_W'(ALERT_FILT)) begin
          r_alert_run <= r_alert_run + 1'b1;
          if (r_alert_run == AF_W'(ALERT_FILT - 1) && r_alert_cnt != 8'hFF) begin
            r_alert_cnt <= r_alert_cnt + 8'd1;
          end
        end
      end else begin
        r_alert_run <= '0;
      end
    end
  end

  assign o_alert_cnt = r_alert_cnt;
`else
  logic w_unused_alert_n;
  assign w_unused_alert_n = i_alert_n;
  assign o_alert_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_ddr5_power_sequencer.sv
// Directed testbench for ddr5_power_sequencer.
// Parameters: BULK_DLY=4, PGOOD_TO=10, RST_HOLD=8, INIT_DLY=6, ALERT_FILT=3.
// The expected outputs are packed into one vector:
//   {state[2:0], bulk, mgmt, reset_n, ck_en, ready, fault, code[1:0]}
module tb_ddr5_power_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       shutdown = 1'b0;
  logic       fault_clr = 1'b0;
  logic       pgood = 1'b0;
  logic       alert_n = 1'b1;
  logic       vin_bulk_en;
  logic       vin_mgmt_en;
  logic       ddr5_reset_n;
  logic       ck_en;
  logic       ready;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state;
  logic [7:0] alert_cnt;

  int checks = 0;
  int failures = 0;

  ddr5_power_sequencer #(
    .CNT_W      (24),
    .BULK_DLY   (4),
    .PGOOD_TO   (10),
    .RST_HOLD   (8),
    .INIT_DLY   (6),
    .ALERT_FILT (3)
  ) dut (
    .i_sys_clk      (clk),
    .i_sys_rst_n    (rst_n),
    .i_start        (start),
    .i_shutdown     (shutdown),
    .i_fault_clr    (fault_clr),
    .i_pgood        (pgood),
    .i_alert_n      (alert_n),
    .o_vin_bulk_en  (vin_bulk_en),
    .o_vin_mgmt_en  (vin_mgmt_en),
    .o_ddr5_reset_n (ddr5_reset_n),
    .o_ck_en        (ck_en),
    .o_ready        (ready),
    .o_fault        (fault),
    .o_fault_code   (fault_code),
    .o_state        (state),
    .o_alert_cnt    (alert_cnt)
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {state, vin_bulk_en, vin_mgmt_en, ddr5_reset_n, ck_en, ready, fault, fault_code};

  localparam logic [10:0] E_OFF   = {3'd0, 6'b000000, 2'd0};
  localparam logic [10:0] E_BULK  = {3'd1, 6'b100000, 2'd0};
  localparam logic [10:0] E_PGOOD = {3'd2, 6'b110000, 2'd0};
  localparam logic [10:0] E_RST   = {3'd3, 6'b110000, 2'd0};
  localparam logic [10:0] E_INIT  = {3'd4, 6'b111000, 2'd0};
  localparam logic [10:0] E_READY = {3'd5, 6'b111110, 2'd0};
  localparam logic [10:0] E_FLT1  = {3'd6, 6'b000001, 2'd1};
  localparam logic [10:0] E_FLT2  = {3'd6, 6'b000001, 2'd2};

`ifdef DDR5_PWRSEQ_ALERT_MON_EN
  localparam bit ALERT_ON = 1'b1;
`else
  localparam bit ALERT_ON = 1'b0;
`endif

  // Advance n clock edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pgood = 1'b0; alert_n = 1'b1;
    step(2);
    checks++;
    if (obs !== E_OFF) begin
      failures++; $display("FAIL reset_outputs obs=%h exp=%h", obs, E_OFF);
    end
    checks++;
    if (alert_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_alert_cnt got=%0d exp=0", alert_cnt);
    end
    rst_n = 1'b1;
    // start and shutdown together in S_OFF must leave the FSM in S_OFF.
    start = 1'b1; shutdown = 1'b1; step(1); start = 1'b0; shutdown = 1'b0;
    checks++;
    if (obs !== E_OFF) begin
      failures++; $display("FAIL off_start_shutdown obs=%h exp=%h", obs, E_OFF);
    end
    $display("test_reset done");
  endtask

  // Full power-up with pgood already high and synced. Ends in S_READY.
  task automatic test_nominal(input string tag);
    pulse_start();
    checks++;
    if (obs !== E_BULK) begin
      failures++; $display("FAIL %s_bulk_on obs=%h exp=%h", tag, obs, E_BULK);
    end
    step(3);
    checks++;
    if (obs !== E_BULK) begin
      failures++; $display("FAIL %s_bulk_end obs=%h exp=%h", tag, obs, E_BULK);
    end
    step(1);
    checks++;
    if (obs !== E_PGOOD) begin
      failures++; $display("FAIL %s_mgmt_on obs=%h exp=%h", tag, obs, E_PGOOD);
    end
    step(1);
    checks++;
    if (obs !== E_RST) begin
      failures++; $display("FAIL %s_rst_entry obs=%h exp=%h", tag, obs, E_RST);
    end
    step(7);
    checks++;
    if (obs !== E_RST) begin
      failures++; $display("FAIL %s_rst_end obs=%h exp=%h", tag, obs, E_RST);
    end
    step(1);
    checks++;
    if (obs !== E_INIT) begin
      failures++; $display("FAIL %s_init_entry obs=%h exp=%h", tag, obs, E_INIT);
    end
    step(5);
    checks++;
    if (obs !== E_INIT) begin
      failures++; $display("FAIL %s_init_end obs=%h exp=%h", tag, obs, E_INIT);
    end
    step(1);
    checks++;
    if (obs !== E_READY) begin
      failures++; $display("FAIL %s_ready obs=%h exp=%h", tag, obs, E_READY);
    end
    $display("test_nominal %s done", tag);
  endtask

  task automatic test_timeout();
    pgood = 1'b0; step(3);
    pulse_start();
    step(4);
    checks++;
    if (obs !== E_PGOOD) begin
      failures++; $display("FAIL to_pgood_entry obs=%h exp=%h", obs, E_PGOOD);
    end
    step(9);
    checks++;
    if (obs !== E_PGOOD) begin
      failures++; $display("FAIL to_pgood_last obs=%h exp=%h", obs, E_PGOOD);
    end
    step(1);
    checks++;
    if (obs !== E_FLT1) begin
      failures++; $display("FAIL to_fault obs=%h exp=%h", obs, E_FLT1);
    end
    // start is ignored in S_FAULT.
    pulse_start();
    checks++;
    if (obs !== E_FLT1) begin
      failures++; $display("FAIL to_start_ignored obs=%h exp=%h", obs, E_FLT1);
    end
    fault_clr = 1'b1; step(1); fault_clr = 1'b0;
    checks++;
    if (obs !== E_OFF) begin
      failures++; $display("FAIL to_clear obs=%h exp=%h", obs, E_OFF);
    end
    $display("test_timeout done");
  endtask

  task automatic test_pgood_loss();
    pgood = 1'b1; step(3);
    test_nominal("loss");
    pgood = 1'b0;
    step(2);
    checks++;
    if (obs !== E_READY) begin
      failures++; $display("FAIL loss_sync_delay obs=%h exp=%h", obs, E_READY);
    end
    step(1);
    checks++;
    if (obs !== E_FLT2) begin
      failures++; $display("FAIL loss_fault obs=%h exp=%h", obs, E_FLT2);
    end
    // shutdown does not leave S_FAULT.
    shutdown = 1'b1; step(1); shutdown = 1'b0;
    checks++;
    if (obs !== E_FLT2) begin
      failures++; $display("FAIL loss_shutdown_ignored obs=%h exp=%h", obs, E_FLT2);
    end
    fault_clr = 1'b1; step(1); fault_clr = 1'b0;
    checks++;
    if (obs !== E_OFF) begin
      failures++; $display("FAIL loss_clear obs=%h exp=%h", obs, E_OFF);
    end
    $display("test_pgood_loss done");
  endtask

  task automatic test_shutdown();
    pgood = 1'b1; step(3);
    pulse_start();
    step(5);
    step(2);
    checks++;
    if (obs !== E_RST) begin
      failures++; $display("FAIL sd_in_rst obs=%h exp=%h", obs, E_RST);
    end
    shutdown = 1'b1; step(1); shutdown = 1'b0;
    checks++;
    if (obs !== E_OFF) begin
      failures++; $display("FAIL sd_off obs=%h exp=%h", obs, E_OFF);
    end
    step(2);
    checks++;
    if (obs !== E_OFF) begin
      failures++; $display("FAIL sd_stays_off obs=%h exp=%h", obs, E_OFF);
    end
    test_nominal("restart");
    $display("test_shutdown done");
  endtask

  task automatic test_async_reset();
    // Entered in S_READY. Assert reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_OFF) begin
      failures++; $display("FAIL async_reset obs=%h exp=%h", obs, E_OFF);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    step(3);
    checks++;
    if (obs !== E_OFF) begin
      failures++; $display("FAIL async_release obs=%h exp=%h", obs, E_OFF);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_alert();
    logic [7:0] exp_cnt;
    pgood = 1'b1; alert_n = 1'b1; step(3);
    test_nominal("alert");
    // A 2-cycle low pulse is below the filter length.
    alert_n = 1'b0; step(2); alert_n = 1'b1; step(4);
    checks++;
    if (alert_cnt !== 8'd0) begin
      failures++; $display("FAIL alert_short got=%0d exp=0", alert_cnt);
    end
    // A 3-cycle low pulse is exactly the filter length.
    alert_n = 1'b0; step(3); alert_n = 1'b1; step(4);
    exp_cnt = ALERT_ON ? 8'd1 : 8'd0;
    checks++;
    if (alert_cnt !== exp_cnt) begin
      failures++; $display("FAIL alert_exact got=%0d exp=%0d", alert_cnt, exp_cnt);
    end
    // A long low pulse adds one event only.
    alert_n = 1'b0; step(10); alert_n = 1'b1; step(4);
    exp_cnt = ALERT_ON ? 8'd2 : 8'd0;
    checks++;
    if (alert_cnt !== exp_cnt) begin
      failures++; $display("FAIL alert_long got=%0d exp=%0d", alert_cnt, exp_cnt);
    end
    checks++;
    if (obs !== E_READY) begin
      failures++; $display("FAIL alert_still_ready obs=%h exp=%h", obs, E_READY);
    end
    // Entering S_OFF clears the count.
    shutdown = 1'b1; step(1); shutdown = 1'b0;
    checks++;
    if (alert_cnt !== 8'd0 || obs !== E_OFF) begin
      failures++; $display("FAIL alert_clear_on_off cnt=%0d obs=%h exp_cnt=0 exp_obs=%h", alert_cnt, obs, E_OFF);
    end
    $display("test_alert done");
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_pgood_loss();
    test_shutdown();
    test_async_reset();
    test_alert();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
